// File: rtl/ntsc_zbt_packer.sv
// ntsc_zbt_packer: packs decoded video pixels into 36-bit ZBT words.
// Each word carries a {row, field, word_idx} address. Words queue in a small FIFO
// that is drained by the ZBT arbiter through a req/ack handshake.
module ntsc_zbt_packer #(
  parameter int PIX_W      = 18,
  parameter int PPW        = 2,
  parameter int ROW_W      = 9,
  parameter int MAX_COLS   = 720,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [2:0]       fvh,
  input  logic [1:0]       mode,
  output logic             wr_req,
  output logic [18:0]      wr_addr,
  output logic [35:0]      wr_data,
  input  logic             wr_ack,
  output logic             overflow,
  output logic [15:0]      drop_count,
  output logic             field_done
);

  localparam int WI_W   = 18 - ROW_W;
  localparam int LANE_W = PIX_W * PPW;
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int COL_W  = $clog2(MAX_COLS + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = 19 + 36;

  // Line/field tracking and the partially filled word
  logic [COL_W-1:0]  col, col_n;
  logic [ROW_W-1:0]  row, row_n;
  logic              field, field_n;
  logic [WI_W-1:0]   wi, wi_n;
  logic [SLOT_W-1:0] slot, slot_n;
  logic [LANE_W-1:0] acc, acc_n;
  logic [18:0]       addr_acc, addr_n;
  logic [1:0]        mode_act, mode_n;
  logic [2:0]        fvh_q;

  // Word handed to the FIFO this cycle
  logic              push;
  logic [LANE_W-1:0] push_word;
  logic [18:0]       push_addr;
  logic [LANE_W-1:0] lane_word;
  logic [18:0]       cur_addr;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              full, pop, push_ok;
  logic [ENT_W-1:0]  head;

  logic hb_rise, vb_rise, accept;

  assign hb_rise = fvh[0] & ~fvh_q[0];
  assign vb_rise = fvh[1] & ~fvh_q[1];
  assign accept  = pix_valid & ~fvh[1] & ~fvh[0] & (col < COL_W'(MAX_COLS));

  // Next-state of the packer: place the pixel, decide whether a word leaves, handle line/field edges
  always_comb begin
    col_n     = col;
    row_n     = row;
    field_n   = field;
    wi_n      = wi;
    slot_n    = slot;
    acc_n     = acc;
    addr_n    = addr_acc;
    mode_n    = mode_act;
    push      = 1'b0;
    push_word = '0;
    push_addr = '0;
    lane_word = acc;
    cur_addr  = addr_acc;

    if (accept) begin
      col_n = col + 1'b1;
      if (mode_act == 2'd2) begin
        for (int i = 0; i < PPW; i++) begin
          push_word[(PPW-i)*PIX_W-1 -: PIX_W] = pix_data;
        end
        push      = 1'b1;
        push_addr = {row, field, wi};
        wi_n      = wi + 1'b1;
      end else if ((mode_act != 2'd1) || !col[0]) begin
        // Slot 0 sits in the MSB lane; the address is fixed by the first pixel of the word
        for (int i = 0; i < PPW; i++) begin
          if (slot == SLOT_W'(i)) begin
            lane_word[(PPW-i)*PIX_W-1 -: PIX_W] = pix_data;
          end
        end
        if (slot == '0) begin
          cur_addr = {row, field, wi};
        end
        if (slot == SLOT_W'(PPW-1)) begin
          push      = 1'b1;
          push_word = lane_word;
          push_addr = cur_addr;
          acc_n     = '0;
          slot_n    = '0;
          wi_n      = wi + 1'b1;
        end else begin
          acc_n  = lane_word;
          addr_n = cur_addr;
          slot_n = slot + 1'b1;
        end
      end
    end

    if (hb_rise) begin
      // A word completed by this cycle's pixel already left, so only a true partial is flushed
      if (!push && (slot_n != '0)) begin
        push      = 1'b1;
        push_word = acc_n;
        push_addr = addr_n;
      end
      col_n  = '0;
      wi_n   = '0;
      slot_n = '0;
      acc_n  = '0;
      mode_n = mode;
      if (!fvh[1] && (row != {ROW_W{1'b1}})) begin
        row_n = row + 1'b1;
      end
    end

    if (vb_rise) begin
      row_n   = '0;
      field_n = fvh[2];
    end
  end

  // Packer state registers and the edge-detect history of fvh
  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      field      <= 1'b0;
      wi         <= '0;
      slot       <= '0;
      acc        <= '0;
      addr_acc   <= '0;
      mode_act   <= 2'd0;
      fvh_q      <= 3'b000;
      field_done <= 1'b0;
    end else begin
      col        <= col_n;
      row        <= row_n;
      field      <= field_n;
      wi         <= wi_n;
      slot       <= slot_n;
      acc        <= acc_n;
      addr_acc   <= addr_n;
      mode_act   <= mode_n;
      fvh_q      <= fvh;
      field_done <= vb_rise;
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = wr_req & wr_ack;
  assign push_ok = push & (~full | pop);

  // FIFO storage; contents are don't-care until written, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= {push_addr, 36'(push_word)};
    end
  end

  // FIFO pointers, occupancy and drop accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end else if (push) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rptr];
  assign wr_req  = (count != '0);
  assign wr_addr = wr_req ? head[ENT_W-1 -: 19] : 19'd0;
  assign wr_data = wr_req ? head[35:0] : 36'd0;

endmodule

// File: tb/tb_ntsc_zbt_packer.sv
// Scoreboard bench for ntsc_zbt_packer: directed pixel streams push expected words,
// a negedge monitor compares every word the arbiter side pops.
module tb_ntsc_zbt_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [17:0] pix_data;
  logic [2:0]  fvh;
  logic [1:0]  mode;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_ack;
  logic        overflow;
  logic [15:0] drop_count;
  logic        field_done;

  int total = 0;
  int bad   = 0;
  logic [54:0] sbq [$];
  logic [54:0] mon_e;

  always #5 clk = ~clk;

  ntsc_zbt_packer dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .fvh        (fvh),
    .mode       (mode),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .overflow   (overflow),
    .drop_count (drop_count),
    .field_done (field_done)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [17:0] d);
    pix_valid = v;
    pix_data  = d;
    tick();
    pix_valid = 1'b0;
    pix_data  = '0;
  endtask

  task automatic expectWord(input logic [18:0] a, input logic [35:0] d);
    sbq.push_back({a, d});
  endtask

  task automatic hblankPulse();
    fvh[0] = 1'b1;
    tick();
    fvh[0] = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("drain", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: every word the arbiter consumes must match the oldest expected word
  always @(negedge clk) begin
    if (!reset && wr_req && wr_ack) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_word: got addr %0h data %0h expected none", wr_addr, wr_data);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("wr_addr", 64'(wr_addr), 64'(mon_e[54:36]));
        checkOutput("wr_data", 64'(wr_data), 64'(mon_e[35:0]));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_data = '0; fvh = 3'b000; mode = 2'd0; wr_ack = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    checkOutput("rst_wr_req", 64'(wr_req), 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_drop", 64'(drop_count), 64'd0);
    checkOutput("rst_field_done", 64'(field_done), 64'd0);
    reset = 1'b0;
    tick();

    // Field 1 via vblank rise, then three lines to reach row 3
    fvh = 3'b110;
    tick();
    @(negedge clk);
    checkOutput("field_done_pulse", 64'(field_done), 64'd1);
    tick();
    @(negedge clk);
    checkOutput("field_done_single", 64'(field_done), 64'd0);
    fvh = 3'b100;
    tick();
    hblankPulse(); hblankPulse(); hblankPulse();

    // Mode 0 basic word, row 3 field 1, with latency
    expectWord(19'h00E00, 36'h000040002);
    applyStimulus(1'b1, 18'h00001);
    applyStimulus(1'b1, 18'h00002);
    @(negedge clk);
    checkOutput("latency_wr_req", 64'(wr_req), 64'd1);
    drain();

    // Five pixels then flush, next line restarts at word 0 on row+1
    hblankPulse();
    expectWord(19'h01200, 36'h000440012);
    expectWord(19'h01201, 36'h0004C0014);
    expectWord(19'h01202, 36'h000540000);
    expectWord(19'h01600, 36'h000840022);
    applyStimulus(1'b1, 18'h11); applyStimulus(1'b1, 18'h12);
    applyStimulus(1'b1, 18'h13); applyStimulus(1'b1, 18'h14);
    applyStimulus(1'b1, 18'h15);
    hblankPulse();
    applyStimulus(1'b1, 18'h21); applyStimulus(1'b1, 18'h22);
    drain();

    // Mode 1 decimation; mode 2 requested mid-line only takes hold at the next hblank
    mode = 2'd1;
    hblankPulse();
    expectWord(19'h01A00, 36'h000040003);
    expectWord(19'h01A01, 36'h000140007);
    expectWord(19'h01A02, 36'h000240000);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 18'(i));
    mode = 2'd2;
    applyStimulus(1'b1, 18'd9);
    applyStimulus(1'b1, 18'd10);
    hblankPulse();
    expectWord(19'h01E00, 36'hFFFFFFFFF);
    expectWord(19'h01E01, 36'h000140005);
    applyStimulus(1'b1, 18'h3FFFF);
    applyStimulus(1'b1, 18'h00005);
    mode = 2'd0;
    hblankPulse();
    hblankPulse();
    drain();

    // Overflow: 9 words into a depth-8 FIFO with no acks, then full+pop+push together
    wr_ack = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) expectWord(19'h02600 + 19'(k), {18'(2*k+1), 18'(2*k+2)});
      applyStimulus(1'b1, 18'(2*k+1));
      applyStimulus(1'b1, 18'(2*k+2));
    end
    @(negedge clk);
    checkOutput("overflow_set", 64'(overflow), 64'd1);
    checkOutput("drop_count_1", 64'(drop_count), 64'd1);
    checkOutput("stall_wr_req", 64'(wr_req), 64'd1);
    checkOutput("stall_head_addr", 64'(wr_addr), 64'h02600);
    checkOutput("stall_head_data", 64'(wr_data), 64'h000040002);
    expectWord(19'h02609, {18'd19, 18'd20});
    applyStimulus(1'b1, 18'd19);
    pix_valid = 1'b1;
    pix_data  = 18'd20;
    wr_ack    = 1'b1;
    tick();
    pix_valid = 1'b0;
    drain();
    checkOutput("drop_count_still_1", 64'(drop_count), 64'd1);
    checkOutput("overflow_sticky", 64'(overflow), 64'd1);

    // MAX_COLS: 721st pixel of a line must be ignored (no flush word afterwards)
    hblankPulse();
    for (int k = 0; k < 360; k++) expectWord(19'h02A00 + 19'(k), {18'(2*k+1), 18'(2*k+2)});
    for (int j = 0; j <= 720; j++) applyStimulus(1'b1, 18'(j+1));
    hblankPulse();
    drain();

    // vblank rise: field 0, row 0; hblank inside vblank keeps row 0
    fvh = 3'b010;
    tick();
    @(negedge clk);
    checkOutput("field_done_vb2", 64'(field_done), 64'd1);
    fvh = 3'b011;
    tick();
    fvh = 3'b010;
    tick();
    fvh = 3'b000;
    tick();
    expectWord(19'h00000, 36'h0001C0008);
    applyStimulus(1'b1, 18'h7);
    applyStimulus(1'b1, 18'h8);
    drain();

    // Reset mid-word discards the partial pixel
    applyStimulus(1'b1, 18'h9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_wr_req", 64'(wr_req), 64'd0);
    expectWord(19'h00000, 36'h00028000B);
    applyStimulus(1'b1, 18'hA);
    applyStimulus(1'b1, 18'hB);
    drain();
    tick(); tick();

    checkOutput("queue_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
